// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
// Holds the controller state encoding and the select-to-one-hot function.
package dec_pkg;

    localparam int DEC_MAX_SEL_W = 8;
    localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } dec_state_e;

    // Callers take the low 2**SEL_W bits of the result.
    function automatic logic [DEC_MAX_OUT_W-1:0] onehot(input logic [DEC_MAX_SEL_W-1:0] sel);
        logic [DEC_MAX_OUT_W-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Loadable down-counter that times how long each strobe dwells.
// The zero flag marks the last cycle of the current strobe.
module dec_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot strobe generator with programmable dwell.
// Scan mode (walk the strobe across every output) exists only with ONEHOT_SCAN_DECODER_SCAN_EN.
module onehot_scan_decoder
    import dec_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8,
    localparam int OUT_W  = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_mode,
    input  logic [DWELL_W-1:0] in_dwell,
    input  logic               abort,
    output logic [OUT_W-1:0]   y,
    output logic               busy,
    output logic               done
);

    dec_state_e         state_q, state_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               done_q, done_d;

    logic               accept;
    logic               cnt_load;
    logic               cnt_dec;
    logic [DWELL_W-1:0] cnt_load_val;
    logic               cnt_zero;

    logic [SEL_W-1:0]         oh_sel;
    logic [DEC_MAX_OUT_W-1:0] oh_wide;
    logic [OUT_W-1:0]         sel_oh;
    logic                     unused_oh;

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
`else
    logic               unused_mode;
    assign unused_mode = in_mode;
`endif

    assign in_ready = (state_q == IDLE) && !abort && !rst;
    assign accept   = in_valid && in_ready;

    // While scanning, the decoded select is the next index, so a step reuses the same decoder.
    always_comb begin
        oh_sel = in_sel;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
        if (state_q == SCAN) begin
            oh_sel = idx_q + SEL_W'(1);
        end
`endif
    end

    assign oh_wide   = onehot(DEC_MAX_SEL_W'(oh_sel));
    assign sel_oh    = oh_wide[OUT_W-1:0];
    assign unused_oh = ^oh_wide;

    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = in_dwell;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
        idx_d        = idx_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    y_d      = sel_oh;
                    cnt_load = 1'b1;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
                    if (in_mode) begin
                        state_d = SCAN;
                        idx_d   = in_sel;
                        step_d  = SEL_W'(OUT_W - 1);
                        dwell_d = in_dwell;
                    end else begin
                        state_d = HOLD;
                    end
`else
                    state_d = HOLD;
`endif
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    y_d     = '0;
                end else if (cnt_zero) begin
                    state_d = IDLE;
                    y_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    y_d     = '0;
                end else if (cnt_zero) begin
                    if (step_q == '0) begin
                        state_d = IDLE;
                        y_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d        = idx_q + SEL_W'(1);
                        y_d          = sel_oh;
                        cnt_load     = 1'b1;
                        cnt_load_val = dwell_q;
                        step_d       = step_q - SEL_W'(1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                y_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            done_q  <= 1'b0;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
            idx_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            done_q  <= done_d;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
            idx_q   <= idx_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
`endif
        end
    end

    dec_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign y    = y_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed self-checking bench for onehot_scan_decoder at SEL_W=3, DWELL_W=8.
// Scan scenarios are compiled in only with ONEHOT_SCAN_DECODER_SCAN_EN.
module tb_onehot_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_sel = '0;
    logic       in_mode = 1'b0;
    logic [7:0] in_dwell = '0;
    logic       abort = 1'b0;
    logic [7:0] y;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    onehot_scan_decoder #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_mode  (in_mode),
        .in_dwell (in_dwell),
        .abort    (abort),
        .y        (y),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] sel, input logic mode, input logic [7:0] dwell);
        in_valid = 1'b1;
        in_sel   = sel;
        in_mode  = mode;
        in_dwell = dwell;
        tick();
        in_valid = 1'b0;
        in_mode  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL rst_y got %h want 00", y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_rel_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_single_dwell0();
        in_valid = 1'b1; in_sel = 3'd5; in_mode = 1'b0; in_dwell = 8'd0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL d0_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (y !== 8'h20) begin errors++; $display("[TB] FAIL d0_y got %h want 20", y); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL d0_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL d0_done_early got %b want 0", done); end
        tick();
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL d0_y_end got %h want 00", y); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL d0_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL d0_busy_end got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL d0_done_pulse got %b want 0", done); end
    endtask

    task automatic test_single_dwell3();
        request(3'd0, 1'b0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            checks++; if (y !== 8'h01) begin errors++; $display("[TB] FAIL d3_y[%0d] got %h want 01", i, y); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL d3_ready[%0d] got %b want 0", i, in_ready); end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL d3_done[%0d] got %b want 0", i, done); end
            tick();
        end
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL d3_y_end got %h want 00", y); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL d3_done got %b want 1", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL d3_done_pulse got %b want 0", done); end
    endtask

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    task automatic test_scan();
        logic [7:0] exp_seq [16];
        exp_seq = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02, 8'h02,
                    8'h04, 8'h04, 8'h08, 8'h08, 8'h10, 8'h10, 8'h20, 8'h20};
        request(3'd6, 1'b1, 8'd1);
        for (int i = 0; i < 16; i++) begin
            checks++; if (y !== exp_seq[i]) begin errors++; $display("[TB] FAIL scan_y[%0d] got %h want %h", i, y, exp_seq[i]); end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL scan_done[%0d] got %b want 0", i, done); end
            tick();
        end
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL scan_y_end got %h want 00", y); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL scan_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL scan_busy_end got %b want 0", busy); end
        tick();
    endtask
`else
    task automatic test_mode_ignored();
        request(3'd7, 1'b1, 8'd1);
        for (int i = 0; i < 2; i++) begin
            checks++; if (y !== 8'h80) begin errors++; $display("[TB] FAIL nomode_y[%0d] got %h want 80", i, y); end
            tick();
        end
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL nomode_y_end got %h want 00", y); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL nomode_done got %b want 1", done); end
        tick();
    endtask
`endif

    task automatic test_abort();
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
        request(3'd0, 1'b1, 8'd3);
`else
        request(3'd0, 1'b0, 8'd3);
`endif
        checks++; if (y !== 8'h01) begin errors++; $display("[TB] FAIL ab_y got %h want 01", y); end
        tick();
        abort = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ab_ready got %b want 0", in_ready); end
        tick();
        abort = 1'b0;
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL ab_y_end got %h want 00", y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ab_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL ab_done got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL ab_done_late got %b want 0", done); end
        abort = 1'b1; in_valid = 1'b1; in_sel = 3'd3;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ab_idle_ready got %b want 0", in_ready); end
        tick();
        abort = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ab_idle_busy got %b want 0", busy); end
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL ab_idle_y got %h want 00", y); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        request(3'd2, 1'b0, 8'd5);
        tick();
        checks++; if (y !== 8'h04) begin errors++; $display("[TB] FAIL rh_y got %h want 04", y); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rh_ready got %b want 0", in_ready); end
        tick();
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL rh_y_end got %h want 00", y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rh_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rh_done got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rh_ready_held got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rh_ready_rel got %b want 1", in_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rh_done_late got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_sel = 3'd1; in_mode = 1'b0; in_dwell = 8'd0;
        tick();
        in_sel = 3'd3;
        checks++; if (y !== 8'h02) begin errors++; $display("[TB] FAIL b2b_y1 got %h want 02", y); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_busy got %b want 0", in_ready); end
        tick();
        checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL b2b_gap got %h want 00", y); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got %b want 1", done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_done got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (y !== 8'h08) begin errors++; $display("[TB] FAIL b2b_y2 got %h want 08", y); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done2_early got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2 got %b want 1", done); end
        tick();
    endtask

    task automatic test_max_dwell();
        int cycles;
        cycles = 0;
        request(3'd3, 1'b0, 8'd255);
        checks++; if (y !== 8'h08) begin errors++; $display("[TB] FAIL maxd_y got %h want 08", y); end
        for (int i = 0; i < 300 && y !== 8'h00; i++) begin
            cycles++;
            tick();
        end
        checks++; if (cycles != 256) begin errors++; $display("[TB] FAIL maxd_len got %0d want 256", cycles); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL maxd_done got %b want 1", done); end
        tick();
    endtask

    initial begin
        $display("[TB] onehot_scan_decoder bench start");
        test_reset();
        test_single_dwell0();
        test_single_dwell3();
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
        test_scan();
`else
        test_mode_ignored();
`endif
        test_abort();
        test_reset_mid_hold();
        test_back_to_back();
        test_max_dwell();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
